crc_frame_arbiter: RTL

Frame-level arbiter and sequencer that shares a single 32-bit-parallel CRC-16 engine (polynomial 1+x^3+x^4+x^7+x^8+x^10+x^14+x^15+x^16, seed 0xFFFF) between NUM_REQ frame requesters, typically the TX and RX frame paths. For each granted frame it re-seeds the engine, streams the frame's words into it with a valid/ready handshake, and returns the final CRC with a one-cycle done strobe.

---
 rtl/crc_arb_pkg.sv | 36 +++
 rtl/crc_frame_arbiter_crc16.sv | 30 +++
 rtl/crc_frame_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/crc_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// crc_arb_pkg : shared types, widths and the CRC-16 word-update function
// Rev 1.0 - initial release
// ============================================================================
package crc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  localparam int              CRC_W    = 16;
  localparam int              DATA_W   = 32;
  localparam logic [CRC_W-1:0] CRC_SEED = 16'hFFFF;
  // x^15+x^14+x^10+x^8+x^7+x^4+x^3+1 (x^16 implicit)
  localparam logic [CRC_W-1:0] CRC_POLY = 16'hC599;

  // Non-reflected, MSB-first update over one 32-bit word.
  function automatic logic [CRC_W-1:0] crc16_word(input logic [CRC_W-1:0]  crc_in,
                                                  input logic [DATA_W-1:0] word);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ word[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc_frame_arbiter_crc16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// crc_frame_arbiter_crc16 : 32-bit-parallel CRC-16 engine, resets to seed
// Rev 1.0 - initial release
// ============================================================================
module crc_frame_arbiter_crc16
  import crc_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CRC_W-1:0]  crc_o
);

  logic [CRC_W-1:0] crc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= CRC_SEED;
    end else if (en_i) begin
      crc_q <= crc16_word(crc_q, data_i);
    end
  end

  assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/crc_frame_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// crc_frame_arbiter : round-robin frame arbiter sharing one CRC-16 engine.
// Optional stall watchdog enabled by `define CRC_ARB_TIMEOUT_EN.
// Rev 1.0 - initial release
// ============================================================================
module crc_frame_arbiter
  import crc_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  input  logic [DATA_W*NUM_REQ-1:0] data_i,
  input  logic [NUM_REQ-1:0]        valid_i,
  input  logic [NUM_REQ-1:0]        last_i,
  output logic [NUM_REQ-1:0]        ready_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [CRC_W-1:0]          crc_res_o,
  output logic [NUM_REQ-1:0]        err_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               init_q, init_d;

  logic [IDX_W-1:0]   w_win;
  logic [IDX_W-1:0]   w_rr_next;
  logic [DATA_W-1:0]  w_data;
  logic               w_valid;
  logic               w_last;
  logic               w_accept;
  logic               w_eng_rst;

`ifdef CRC_ARB_TIMEOUT_EN
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0]        stall_q, stall_d;
  logic [NUM_REQ-1:0] err_q, err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Iterating from the far end lets the nearest requester at/after rr win.
  always_comb begin
    logic [IDX_W-1:0] cand;
    w_win = rr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
      if (req_i[cand]) begin
        w_win = cand;
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        w_data = data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_valid   = valid_i[gidx_q];
  assign w_last    = last_i[gidx_q];
  assign w_accept  = (state_q == RUN) & w_valid;
  assign w_rr_next = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    init_d  = 1'b0;
`ifdef CRC_ARB_TIMEOUT_EN
    stall_d = stall_q;
    err_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d       = INIT;
          gnt_d         = '0;
          gnt_d[w_win]  = 1'b1;
          gidx_d        = w_win;
          init_d        = 1'b1;
        end
      end
      INIT: begin
        state_d = RUN;
`ifdef CRC_ARB_TIMEOUT_EN
        stall_d = '0;
`endif
      end
      RUN: begin
        if (w_accept && w_last) begin
          state_d = DONE;
        end
`ifdef CRC_ARB_TIMEOUT_EN
        if (w_accept) begin
          stall_d = '0;
        end else if (stall_q == STALL_LAST) begin
          // Abort: free the engine without a done strobe.
          state_d = IDLE;
          gnt_d   = '0;
          err_d   = gnt_q;
          rr_d    = w_rr_next;
        end else begin
          stall_d = stall_q + 16'd1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        rr_d    = w_rr_next;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      init_q  <= init_d;
    end
  end

`ifdef CRC_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      err_q   <= '0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = '0;
`endif

  // init_q is a flop, so the engine's reset release stays clock-aligned.
  assign w_eng_rst = rst | init_q;

  crc_frame_arbiter_crc16 u_crc (
    .clk    (clk),
    .rst    (w_eng_rst),
    .en_i   (w_accept),
    .data_i (w_data),
    .crc_o  (crc_res_o)
  );

  assign gnt_o   = gnt_q;
  assign ready_o = (state_q == RUN)  ? gnt_q : '0;
  assign done_o  = (state_q == DONE) ? gnt_q : '0;

endmodule
`default_nettype wire
